apb4_master_ctrl: RTL and testbench
===================================

Name: apb4_master_ctrl

Overview:
Parametrised APB4 master that accepts transfer commands over a valid/ready request port. It drives the APB bus with one-hot slave select and returns one response pulse per command. It succeeds the basic APB master and adds the following:
- PSTRB and PPROT.
- Back-to-back transfers.
- A wait-state timeout.
- Slave-select decode errors.
- Properly registered bus outputs.
It sits between the system-side command source and the APB slave fabric.

Parameters:
ADDR_WIDTH, 8, PADDR / cmd_addr width.
DATA_WIDTH, 16, data width; must be a multiple of 8.
SLAVES_NUM, 4, number of PSEL lines; must be at least 2.
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort; 0 disables the timeout.

Ports:
PCLK  in  1  clock.
PRESETn  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a PCLK edge.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  target address.
cmd_wdata  in  DATA_WIDTH  write data.
cmd_strb  in  DATA_WIDTH/8  byte strobes.
cmd_prot  in  3  protection attributes.
cmd_sel  in  $clog2(SLAVES_NUM)  slave index.
rsp_valid  out  1  one-cycle response pulse; no backpressure.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
rsp_err  out  1  PSLVERR, timeout or decode error.
rsp_timeout  out  1  abort caused by timeout.
PSEL  out  SLAVES_NUM  one-hot slave select.
PENABLE  out  1  access phase.
PADDR  out  ADDR_WIDTH  bus address.
PWRITE  out  1  bus direction.
PWDATA  out  DATA_WIDTH  bus write data.
PSTRB  out  DATA_WIDTH/8  bus strobes.
PPROT  out  3  bus protection.
PRDATA  in  DATA_WIDTH  slave read data.
PREADY  in  1  slave ready.
PSLVERR  in  1  slave error.

Behaviour:
- Reset (asynchronous, while PRESETn=0):
  - state = IDLE, wait counter = 0.
  - All outputs 0, including cmd_ready.
  - An in-flight transfer is dropped and no response is issued.
  - cmd_ready first rises in the cycle after PRESETn deasserts.
- States: IDLE, SETUP, ACCESS, DECERR.
- cmd_ready (combinational):
  - High in IDLE.
  - High in ACCESS when PREADY=1 or the timeout expires this cycle.
  - Low in SETUP and DECERR.
- Acceptance:
  - Registers address, write, wdata, strb and prot into PADDR, PWRITE, PWDATA, PSTRB and PPROT.
  - PSTRB is forced to 0 on reads.
  - These outputs stay stable through SETUP/ACCESS and hold their value until the next acceptance.
- Next state after acceptance:
  - cmd_sel < SLAVES_NUM → SETUP.
  - cmd_sel ≥ SLAVES_NUM → DECERR.
- IDLE: PSEL = 0, PENABLE = 0.
- SETUP:
  - PSEL = 1<<sel, PENABLE = 0.
  - Always moves to ACCESS after exactly 1 cycle.
  - Wait counter is cleared.
- ACCESS: PSEL held, PENABLE = 1.
  - PREADY=1 → transfer completes at this edge.
  - PREADY=0 → wait counter increments.
  - Timeout: counter == TIMEOUT_CYCLES-1 with PREADY=0 (only when TIMEOUT_CYCLES > 0) → abort. ACCESS therefore never exceeds TIMEOUT_CYCLES cycles.
- Exit from ACCESS (on completion or abort):
  - Command accepted in the same cycle → SETUP or DECERR. PENABLE drops for one cycle; PSEL changes to the new slave.
  - No command accepted → IDLE, with PSEL and PENABLE = 0.
- Response for a completed transfer (registered; rsp_valid is high for exactly the cycle after the completion edge):
  - rsp_rdata = PRDATA if read, else 0.
  - rsp_err = PSLVERR, rsp_timeout = 0.
- Response for a timeout abort (cycle after the abort edge):
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- DECERR:
  - Lasts 1 cycle, with PSEL = 0 and PENABLE = 0.
  - Goes to IDLE.
  - Response in the following cycle: rsp_err = 1, rsp_timeout = 0.
- Latency:
  - Accepted at edge k with zero wait states: rsp_valid in cycle k+3.
  - Decode error: rsp_valid in cycle k+2.
  - Back-to-back throughput: one transfer per 2 cycles.
- Responses never overlap and are issued in command order.
- PSLVERR and PRDATA are sampled only when PSEL, PENABLE and PREADY are all high.

Test Plan:
1. Zero-wait write: sel=2, addr=0x3C, wdata=0xA5A5, strb=2'b11, prot=3'b010, PREADY=1 → PSEL=4'b0100 with PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle; rsp_valid at k+3 with rsp_err=0; PSTRB=2'b11.
2. Read with 3 wait states, PRDATA=0x1234 → ACCESS lasts 4 cycles with bus signals stable; rsp_rdata=0x1234; PSTRB=0.
3. cmd_valid held high for two writes (sel 1 then sel 3) → second SETUP immediately follows first ACCESS; PSEL goes 0010 then 1000 with no IDLE cycle; two rsp pulses 2 cycles apart.
4. PREADY stuck at 0, TIMEOUT_CYCLES=16 → PENABLE high for exactly 16 cycles; then rsp_err=1 and rsp_timeout=1; PSEL returns to 0.
5. PREADY=1 with PSLVERR=1 → rsp_err=1, rsp_timeout=0; then, with SLAVES_NUM=3, cmd_sel=3 → PSEL stays 0 and rsp_err=1 arrives 2 cycles after acceptance.
6. PRESETn pulled low mid-ACCESS → PSEL, PENABLE and cmd_ready go to 0 immediately with no rsp_valid; after release, a new read completes normally.

Source files
------------

// File: rtl/apb4_master_ctrl.sv
// APB4 master: turns valid/ready commands into APB4 transfers with PSTRB/PPROT, a wait-state timeout and slave-select decode errors.
// Latency: zero-wait transfer answers 3 cycles after acceptance; a decode error answers 2 cycles after acceptance; back-to-back at 1 transfer per 2 cycles.
// Backpressure: cmd_ready is high only in IDLE or in the last ACCESS cycle; rsp_valid is a single-cycle pulse with no backpressure.
//
// Ports:
//   PCLK, PRESETn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/addr/wdata/strb/prot/sel   command payload (sel = slave index)
//   rsp_valid/rdata/err/timeout   response pulse, one per accepted command
//   PSEL..PPROT                   registered APB4 request outputs
//   PRDATA/PREADY/PSLVERR         APB4 completer inputs
module apb4_master_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int SLAVES_NUM     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]       cmd_strb,
  input  logic [2:0]                    cmd_prot,
  input  logic [$clog2(SLAVES_NUM)-1:0] cmd_sel,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic [SLAVES_NUM-1:0]         PSEL,
  output logic                          PENABLE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [DATA_WIDTH/8-1:0]       PSTRB,
  output logic [2:0]                    PPROT,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DECERR = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    ready_en_q;
  logic [CNT_WIDTH-1:0]    wait_cnt_q;
  logic [SLAVES_NUM-1:0]   psel_q;
  logic                    penable_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic [2:0]              pprot_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  logic                    xfer_done;
  logic                    xfer_abort;
  logic                    accept;
  logic                    sel_ok;
  logic [SLAVES_NUM-1:0]   sel_onehot;

  assign xfer_done  = (state_q == S_ACCESS) && PREADY;
  assign xfer_abort = TIMEOUT_EN && (state_q == S_ACCESS) && !PREADY && (wait_cnt_q == CNT_LAST);

  // ready_en_q keeps cmd_ready low through reset and the first cycle after it.
  assign cmd_ready  = ready_en_q && ((state_q == S_IDLE) || xfer_done || xfer_abort);
  assign accept     = cmd_valid && cmd_ready;

  assign sel_ok     = (32'(cmd_sel) < SLAVES_NUM);
  assign sel_onehot = sel_ok ? (SLAVES_NUM'(1) << cmd_sel) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      ready_en_q    <= 1'b0;
      wait_cnt_q    <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      ready_en_q    <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;

      case (state_q)
        S_SETUP: begin
          state_q    <= S_ACCESS;
          penable_q  <= 1'b1;
          wait_cnt_q <= '0;
        end
        S_ACCESS: begin
          if (xfer_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            state_q     <= S_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
          end else if (xfer_abort) begin
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
            psel_q        <= '0;
            penable_q     <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
          end
        end
        S_DECERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: ;
      endcase

      // A new command (from IDLE or the final ACCESS cycle) overrides the IDLE return above.
      if (accept) begin
        paddr_q   <= cmd_addr;
        pwrite_q  <= cmd_write;
        pwdata_q  <= cmd_wdata;
        pstrb_q   <= cmd_write ? cmd_strb : '0;
        pprot_q   <= cmd_prot;
        psel_q    <= sel_onehot;
        penable_q <= 1'b0;
        state_q   <= sel_ok ? S_SETUP : S_DECERR;
      end
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master_ctrl.sv
// Bench for apb4_master_ctrl: per-cycle vector table plus directed timeout, decode-error and reset sequences.
// Latency: stimulus applied 1 time unit after PCLK rise, outputs sampled on PCLK fall.
// Backpressure: the bench models the completer through PREADY/PSLVERR/PRDATA inputs.
module tb_apb4_master_ctrl;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_valid3;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic [1:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic [1:0]  cmd_sel;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE;
  logic [15:0] rsp_rdata, PWDATA;
  logic [3:0]  PSEL;
  logic [7:0]  PADDR;
  logic [1:0]  PSTRB;
  logic [2:0]  PPROT;

  logic        d3_cmd_ready, d3_rsp_valid, d3_rsp_err, d3_rsp_timeout, d3_PENABLE, d3_PWRITE;
  logic [15:0] d3_rsp_rdata, d3_PWDATA;
  logic [2:0]  d3_PSEL;
  logic [7:0]  d3_PADDR;
  logic [1:0]  d3_PSTRB;
  logic [2:0]  d3_PPROT;

  apb4_master_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb4_master_ctrl #(.SLAVES_NUM(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid3), .cmd_ready(d3_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .cmd_sel(cmd_sel),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .rsp_timeout(d3_rsp_timeout),
    .PSEL(d3_PSEL), .PENABLE(d3_PENABLE), .PADDR(d3_PADDR), .PWRITE(d3_PWRITE),
    .PWDATA(d3_PWDATA), .PSTRB(d3_PSTRB), .PPROT(d3_PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [1:0]  sel;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic [2:0]  prot;
    logic        rdy;
    logic        slverr;
    logic [15:0] prdata;
  } in_t;

  typedef struct packed {
    logic        crdy;
    logic [3:0]  psel;
    logic        pen;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [1:0]  pstrb;
    logic [2:0]  pprot;
    logic        pwrite;
    logic        rvld;
    logic        rerr;
    logic        rto;
    logic [15:0] rdata;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t x);
    cmd_valid = x.vld;
    cmd_write = x.wr;
    cmd_sel   = x.sel;
    cmd_addr  = x.addr;
    cmd_wdata = x.wdata;
    cmd_strb  = x.strb;
    cmd_prot  = x.prot;
    PREADY    = x.rdy;
    PSLVERR   = x.slverr;
    PRDATA    = x.prdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t idle0;
    in_t idle1;
    int  pen_cnt;
    bit  got;

    idle0 = '{1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 16'h0000};
    idle1 = '{1'b0, 1'b0, 2'd0, 8'h00, 16'h0000, 2'd0, 3'd0, 1'b1, 1'b0, 16'h0000};

    // Zero-wait write to slave 2.
    vecs[0]  = '{'{1'b1,1'b1,2'd2,8'h3C,16'hA5A5,2'd3,3'd2,1'b1,1'b0,16'h0000},
                 '{1'b1,4'h0,1'b0,8'h00,16'h0000,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,16'h0000}};
    vecs[1]  = '{idle1, '{1'b0,4'h4,1'b0,8'h3C,16'hA5A5,2'd3,3'd2,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[2]  = '{idle1, '{1'b1,4'h4,1'b1,8'h3C,16'hA5A5,2'd3,3'd2,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[3]  = '{idle0, '{1'b1,4'h0,1'b0,8'h3C,16'hA5A5,2'd3,3'd2,1'b1,1'b1,1'b0,1'b0,16'h0000}};
    // Read from slave 0 with 3 wait states; strobes must be dropped.
    vecs[4]  = '{'{1'b1,1'b0,2'd0,8'h55,16'hDEAD,2'd3,3'd0,1'b0,1'b0,16'h0000},
                 '{1'b1,4'h0,1'b0,8'h3C,16'hA5A5,2'd3,3'd2,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[5]  = '{idle0, '{1'b0,4'h1,1'b0,8'h55,16'hDEAD,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,16'h0000}};
    vecs[6]  = '{idle0, '{1'b0,4'h1,1'b1,8'h55,16'hDEAD,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,16'h0000}};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{'{1'b0,1'b0,2'd0,8'h00,16'h0000,2'd0,3'd0,1'b1,1'b0,16'h1234},
                 '{1'b1,4'h1,1'b1,8'h55,16'hDEAD,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,16'h0000}};
    vecs[10] = '{idle0, '{1'b1,4'h0,1'b0,8'h55,16'hDEAD,2'd0,3'd0,1'b0,1'b1,1'b0,1'b0,16'h1234}};
    // Back-to-back writes: slave 1 then slave 3.
    vecs[11] = '{'{1'b1,1'b1,2'd1,8'h10,16'h1111,2'd1,3'd1,1'b1,1'b0,16'h0000},
                 '{1'b1,4'h0,1'b0,8'h55,16'hDEAD,2'd0,3'd0,1'b0,1'b0,1'b0,1'b0,16'h0000}};
    vecs[12] = '{'{1'b1,1'b1,2'd3,8'h20,16'h2222,2'd2,3'd4,1'b1,1'b0,16'h0000},
                 '{1'b0,4'h2,1'b0,8'h10,16'h1111,2'd1,3'd1,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[13] = '{vecs[12].i,
                 '{1'b1,4'h2,1'b1,8'h10,16'h1111,2'd1,3'd1,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[14] = '{idle1, '{1'b0,4'h8,1'b0,8'h20,16'h2222,2'd2,3'd4,1'b1,1'b1,1'b0,1'b0,16'h0000}};
    vecs[15] = '{idle1, '{1'b1,4'h8,1'b1,8'h20,16'h2222,2'd2,3'd4,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[16] = '{idle0, '{1'b1,4'h0,1'b0,8'h20,16'h2222,2'd2,3'd4,1'b1,1'b1,1'b0,1'b0,16'h0000}};
    // Write completing with PSLVERR.
    vecs[17] = '{'{1'b1,1'b1,2'd1,8'h40,16'h0F0F,2'd3,3'd0,1'b1,1'b1,16'hBEEF},
                 '{1'b1,4'h0,1'b0,8'h20,16'h2222,2'd2,3'd4,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[18] = '{'{1'b0,1'b0,2'd0,8'h00,16'h0000,2'd0,3'd0,1'b1,1'b1,16'hBEEF},
                 '{1'b0,4'h2,1'b0,8'h40,16'h0F0F,2'd3,3'd0,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[19] = '{vecs[18].i,
                 '{1'b1,4'h2,1'b1,8'h40,16'h0F0F,2'd3,3'd0,1'b1,1'b0,1'b0,1'b0,16'h0000}};
    vecs[20] = '{idle0, '{1'b1,4'h0,1'b0,8'h40,16'h0F0F,2'd3,3'd0,1'b1,1'b1,1'b1,1'b0,16'h0000}};
    vecs[21] = '{idle0, '{1'b1,4'h0,1'b0,8'h40,16'h0F0F,2'd3,3'd0,1'b1,1'b0,1'b0,1'b0,16'h0000}};

    // Reset state.
    PRESETn    = 1'b0;
    cmd_valid3 = 1'b0;
    apply(idle0);
    repeat (3) @(negedge PCLK);
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst PSEL", 32'(PSEL), 32'd0);
    check("rst PENABLE", 32'(PENABLE), 32'd0);
    check("rst PADDR", 32'(PADDR), 32'd0);
    check("rst PSTRB", 32'(PSTRB), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst d3 cmd_ready", 32'(d3_cmd_ready), 32'd0);
    PRESETn = 1'b1;
    #1;
    check("rst release cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge PCLK);
    #1;
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    // Table-driven cycles.
    for (int i = 0; i < NV; i++) begin
      @(posedge PCLK);
      #1;
      apply(vecs[i].i);
      @(negedge PCLK);
      check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e.crdy));
      check($sformatf("v%0d PSEL", i), 32'(PSEL), 32'(vecs[i].e.psel));
      check($sformatf("v%0d PENABLE", i), 32'(PENABLE), 32'(vecs[i].e.pen));
      check($sformatf("v%0d PADDR", i), 32'(PADDR), 32'(vecs[i].e.paddr));
      check($sformatf("v%0d PWDATA", i), 32'(PWDATA), 32'(vecs[i].e.pwdata));
      check($sformatf("v%0d PSTRB", i), 32'(PSTRB), 32'(vecs[i].e.pstrb));
      check($sformatf("v%0d PPROT", i), 32'(PPROT), 32'(vecs[i].e.pprot));
      check($sformatf("v%0d PWRITE", i), 32'(PWRITE), 32'(vecs[i].e.pwrite));
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e.rvld));
      check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].e.rerr));
      check($sformatf("v%0d rsp_timeout", i), 32'(rsp_timeout), 32'(vecs[i].e.rto));
      check($sformatf("v%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e.rdata));
    end

    // Timeout: PREADY stuck low, ACCESS must last exactly 16 cycles.
    @(posedge PCLK);
    #1;
    apply('{1'b1,1'b0,2'd2,8'h5A,16'h0000,2'd0,3'd0,1'b0,1'b0,16'h0000});
    @(negedge PCLK);
    check("to accept cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    pen_cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge PCLK);
      if (PENABLE) begin
        pen_cnt++;
        if (pen_cnt == 15) check("to cmd_ready cycle15", 32'(cmd_ready), 32'd0);
        if (pen_cnt == 16) check("to cmd_ready cycle16", 32'(cmd_ready), 32'd1);
      end
      if (rsp_valid) begin
        got = 1'b1;
        check("to rsp_err", 32'(rsp_err), 32'd1);
        check("to rsp_timeout", 32'(rsp_timeout), 32'd1);
        check("to rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("to PSEL", 32'(PSEL), 32'd0);
        check("to PENABLE", 32'(PENABLE), 32'd0);
      end
    end
    check("to response seen", 32'(got), 32'd1);
    check("to PENABLE cycles", 32'(pen_cnt), 32'd16);

    // Decode error on the 3-slave instance: sel=3 is out of range.
    @(posedge PCLK);
    #1;
    apply('{1'b0,1'b1,2'd3,8'h33,16'h5555,2'd3,3'd0,1'b1,1'b0,16'h0000});
    cmd_valid3 = 1'b1;
    @(negedge PCLK);
    check("dec cmd_ready", 32'(d3_cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid3 = 1'b0;
    @(negedge PCLK);
    check("dec k+1 PSEL", 32'(d3_PSEL), 32'd0);
    check("dec k+1 PENABLE", 32'(d3_PENABLE), 32'd0);
    check("dec k+1 cmd_ready", 32'(d3_cmd_ready), 32'd0);
    check("dec k+1 rsp_valid", 32'(d3_rsp_valid), 32'd0);
    @(negedge PCLK);
    check("dec k+2 rsp_valid", 32'(d3_rsp_valid), 32'd1);
    check("dec k+2 rsp_err", 32'(d3_rsp_err), 32'd1);
    check("dec k+2 rsp_timeout", 32'(d3_rsp_timeout), 32'd0);
    check("dec k+2 PSEL", 32'(d3_PSEL), 32'd0);
    check("dec k+2 cmd_ready", 32'(d3_cmd_ready), 32'd1);
    @(negedge PCLK);
    check("dec k+3 rsp_valid", 32'(d3_rsp_valid), 32'd0);

    // Reset in the middle of ACCESS.
    @(posedge PCLK);
    #1;
    apply('{1'b1,1'b0,2'd1,8'h66,16'h0000,2'd0,3'd0,1'b0,1'b0,16'h0000});
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(posedge PCLK);
    #2;
    check("mid ACCESS PENABLE", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    check("mid rst PSEL", 32'(PSEL), 32'd0);
    check("mid rst PENABLE", 32'(PENABLE), 32'd0);
    check("mid rst cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) begin
      @(negedge PCLK);
      check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    end
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    apply('{1'b1,1'b0,2'd3,8'h77,16'h0000,2'd1,3'd5,1'b1,1'b0,16'h4321});
    @(negedge PCLK);
    check("after rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("after rst cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("after rst SETUP PSEL", 32'(PSEL), 32'd8);
    check("after rst SETUP PENABLE", 32'(PENABLE), 32'd0);
    check("after rst PADDR", 32'(PADDR), 32'h77);
    check("after rst PPROT", 32'(PPROT), 32'd5);
    @(negedge PCLK);
    check("after rst ACCESS PENABLE", 32'(PENABLE), 32'd1);
    @(negedge PCLK);
    check("after rst rsp_valid pulse", 32'(rsp_valid), 32'd1);
    check("after rst rsp_rdata", 32'(rsp_rdata), 32'h4321);
    check("after rst rsp_err", 32'(rsp_err), 32'd0);
    check("after rst PSEL idle", 32'(PSEL), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
